// File: rtl/uart_tx_feeder_if.sv
// Producer/transmitter-side signal bundle for uart_tx_feeder.
// The slave modport is the feeder's view; master is the driving environment.
interface uart_tx_feeder_if #(
  parameter int ADDR_W = 3
);
  logic              i_Enable;
  logic              i_Wr_En;
  logic [7:0]        i_Wr_Byte;
  logic              o_Full;
  logic              o_Empty;
  logic [ADDR_W:0]   o_Count;
  logic              o_Overflow;
  logic              o_Tx_DV;
  logic [7:0]        o_Tx_Byte;
  logic              i_Tx_Active;
  logic              i_Tx_Done;
  logic              o_Busy;
  logic              o_Timeout;

  modport slave (
    input  i_Enable, i_Wr_En, i_Wr_Byte, i_Tx_Active, i_Tx_Done,
    output o_Full, o_Empty, o_Count, o_Overflow, o_Tx_DV, o_Tx_Byte,
           o_Busy, o_Timeout
  );

  modport master (
    output i_Enable, i_Wr_En, i_Wr_Byte, i_Tx_Active, i_Tx_Done,
    input  o_Full, o_Empty, o_Count, o_Overflow, o_Tx_DV, o_Tx_Byte,
           o_Busy, o_Timeout
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch sequencer in front of uart_tx; one frame in flight at a time.
// Optional frame watchdog: define UART_TX_FEEDER_TIMEOUT_EN.
//   state        | meaning
//   IDLE         | waiting for enable and a queued byte
//   WAIT_ACTIVE  | byte launched, waiting for transmitter to go active
//   WAIT_DONE    | frame in flight, waiting for done
//   WAIT_RELEASE | waiting for done to drop before the next launch
module uart_tx_feeder #(
  parameter int ADDR_W         = 3,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input logic             i_Clock,
  input logic             i_Reset,
  uart_tx_feeder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT_ACTIVE, WAIT_DONE, WAIT_RELEASE} state_t;

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t              state_q, state_d;
  logic [7:0]          mem_q [DEPTH];
  logic [ADDR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [ADDR_W:0]     count_q, count_d;
  logic                tx_dv_q, ovf_q;
  logic [7:0]          tx_byte_q;
  logic                full, empty, wr_ok, pop, tmr_exp;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign wr_ok = bus.i_Wr_En && !full;

`ifdef UART_TX_FEEDER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] tmr_q;
  logic             tmo_q, waiting;

  assign waiting = (state_q == WAIT_ACTIVE) || (state_q == WAIT_DONE);
  assign tmr_exp = (tmr_q == '0);

  // Loaded on launch so the first expiry lands TIMEOUT_CYCLES edges after entry.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      tmr_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      if (pop)
        tmr_q <= TMR_W'(TIMEOUT_CYCLES - 1);
      else if (waiting && !tmr_exp)
        tmr_q <= tmr_q - TMR_W'(1);
      tmo_q <= waiting && bus.i_Enable && tmr_exp;
    end
  end

  assign bus.o_Timeout = tmo_q;
`else
  assign tmr_exp       = 1'b0;
  assign bus.o_Timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_Enable && !empty) begin
          pop     = 1'b1;
          state_d = WAIT_ACTIVE;
        end
      end
      WAIT_ACTIVE: begin
        if (!bus.i_Enable || tmr_exp) state_d = IDLE;
        else if (bus.i_Tx_Active)     state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!bus.i_Enable || tmr_exp) state_d = IDLE;
        else if (bus.i_Tx_Done)       state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!bus.i_Enable || !bus.i_Tx_Done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({wr_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      ovf_q     <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + PTR_ONE;
        tx_byte_q <= mem_q[rd_ptr_q];
      end
      count_q <= count_d;
      tx_dv_q <= pop;
      ovf_q   <= bus.i_Wr_En && full;
    end
  end

  // Storage needs no reset; contents are unreachable once pointers clear.
  always_ff @(posedge i_Clock) begin
    if (wr_ok) mem_q[wr_ptr_q] <= bus.i_Wr_Byte;
  end

  assign bus.o_Full     = full;
  assign bus.o_Empty    = empty;
  assign bus.o_Count    = count_q;
  assign bus.o_Overflow = ovf_q;
  assign bus.o_Tx_DV    = tx_dv_q;
  assign bus.o_Tx_Byte  = tx_byte_q;
  assign bus.o_Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder; the watchdog step runs only when
// UART_TX_FEEDER_TIMEOUT_EN is defined.
module tb_uart_tx_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic model_on = 1'b0, m_act = 1'b0, m_done = 1'b0;
  logic man_act = 1'b0, man_done = 1'b0;
  logic pa = 1'b0, pd = 1'b0;
  int   vectors = 0, miscompares = 0, dv_cnt = 0, viol = 0;
  int   dv_snap, nff;
  logic [7:0] sent [$];

  uart_tx_feeder_if #(.ADDR_W(3)) bus ();

  uart_tx_feeder #(.ADDR_W(3), .TIMEOUT_CYCLES(16)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.i_Tx_Active = model_on ? m_act  : man_act;
  assign bus.i_Tx_Done   = model_on ? m_done : man_done;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: active for 3 cycles after a launch, then done for one.
  initial forever begin
    tick();
    if (model_on && bus.o_Tx_DV === 1'b1) begin
      sent.push_back(bus.o_Tx_Byte);
      m_act = 1'b1;
      repeat (3) tick();
      m_act  = 1'b0;
      m_done = 1'b1;
      tick();
      m_done = 1'b0;
    end
  end

  // Counts launches and flags any whose deciding edge saw active/done high.
  initial forever begin
    @(negedge clk);
    if (bus.o_Tx_DV === 1'b1) begin
      dv_cnt++;
      if (pa || pd) viol++;
    end
    pa = bus.i_Tx_Active;
    pd = bus.i_Tx_Done;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bus.i_Enable  = 1'b0;
    bus.i_Wr_En   = 1'b0;
    bus.i_Wr_Byte = 8'h00;
    tick();
    tick();
    chk("rst_dv",    bus.o_Tx_DV,    1'b0);
    chk("rst_byte",  bus.o_Tx_Byte,  8'h00);
    chk("rst_empty", bus.o_Empty,    1'b1);
    chk("rst_full",  bus.o_Full,     1'b0);
    chk("rst_count", bus.o_Count,    4'd0);
    chk("rst_ovf",   bus.o_Overflow, 1'b0);
    chk("rst_busy",  bus.o_Busy,     1'b0);
    chk("rst_tmo",   bus.o_Timeout,  1'b0);
    rst = 1'b0;

    // Single byte, write-to-launch latency
    model_on = 1'b1;
    bus.i_Enable  = 1'b1;
    bus.i_Wr_En   = 1'b1;
    bus.i_Wr_Byte = 8'hA5;
    tick();
    bus.i_Wr_En = 1'b0;
    chk("t1_count_after_wr", bus.o_Count, 4'd1);
    chk("t1_dv_early", bus.o_Tx_DV, 1'b0);
    tick();
    chk("t1_dv", bus.o_Tx_DV, 1'b1);
    chk("t1_byte", bus.o_Tx_Byte, 8'hA5);
    chk("t1_busy", bus.o_Busy, 1'b1);
    chk("t1_count_pop", bus.o_Count, 4'd0);
    tick();
    chk("t1_dv_one_cycle", bus.o_Tx_DV, 1'b0);
    repeat (10) tick();
    chk("t1_busy_end", bus.o_Busy, 1'b0);
    chk("t1_count_end", bus.o_Count, 4'd0);
    chk("t1_dv_total", dv_cnt, 1);
    chk("t1_sent_n", sent.size(), 1);
    if (sent.size() == 1) chk("t1_sent_byte", sent[0], 8'hA5);

    // Eight back-to-back writes through the model
    sent.delete();
    for (int i = 0; i < 8; i++) begin
      bus.i_Wr_En   = 1'b1;
      bus.i_Wr_Byte = 8'(i + 1);
      tick();
    end
    bus.i_Wr_En = 1'b0;
    for (int k = 0; k < 200 && sent.size() < 8; k++) tick();
    repeat (12) tick();
    chk("t2_sent_n", sent.size(), 8);
    for (int i = 0; i < sent.size(); i++) chk($sformatf("t2_order%0d", i), sent[i], 8'(i + 1));
    chk("t2_count_end", bus.o_Count, 4'd0);
    chk("t2_busy_end", bus.o_Busy, 1'b0);

    // Fill with enable low, overflow, then drain
    sent.delete();
    bus.i_Enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.i_Wr_En   = 1'b1;
      bus.i_Wr_Byte = 8'(8'h11 + i);
      tick();
    end
    chk("t3_count8", bus.o_Count, 4'd8);
    chk("t3_full", bus.o_Full, 1'b1);
    chk("t3_ovf_pre", bus.o_Overflow, 1'b0);
    bus.i_Wr_Byte = 8'hFF;
    tick();
    bus.i_Wr_En = 1'b0;
    chk("t3_ovf", bus.o_Overflow, 1'b1);
    chk("t3_count_hold", bus.o_Count, 4'd8);
    tick();
    chk("t3_ovf_pulse", bus.o_Overflow, 1'b0);
    chk("t3_no_pop_disabled", bus.o_Busy, 1'b0);
    bus.i_Enable = 1'b1;
    tick();
    chk("t3_dv", bus.o_Tx_DV, 1'b1);
    chk("t3_byte", bus.o_Tx_Byte, 8'h11);
    chk("t3_count7", bus.o_Count, 4'd7);
    chk("t3_full_drop", bus.o_Full, 1'b0);
    for (int k = 0; k < 300 && sent.size() < 8; k++) tick();
    repeat (12) tick();
    chk("t3_sent_n", sent.size(), 8);
    nff = 0;
    foreach (sent[i]) if (sent[i] == 8'hFF) nff++;
    chk("t3_no_ff", nff, 0);
    if (sent.size() == 8) chk("t3_last", sent[7], 8'h18);
    chk("t3_empty", bus.o_Empty, 1'b1);

    // Enable dropped in WAIT_DONE
    model_on = 1'b0;
    bus.i_Wr_En   = 1'b1;
    bus.i_Wr_Byte = 8'h21;
    tick();
    bus.i_Wr_Byte = 8'h22;
    tick();
    bus.i_Wr_En = 1'b0;
    chk("t4_dv", bus.o_Tx_DV, 1'b1);
    chk("t4_byte", bus.o_Tx_Byte, 8'h21);
    man_act = 1'b1;
    tick();
    chk("t4_busy_done", bus.o_Busy, 1'b1);
    bus.i_Enable = 1'b0;
    tick();
    man_act = 1'b0;
    chk("t4_idle", bus.o_Busy, 1'b0);
    chk("t4_count_kept", bus.o_Count, 4'd1);
    tick();
    tick();
    chk("t4_no_relaunch", bus.o_Tx_DV, 1'b0);
    chk("t4_still_idle", bus.o_Busy, 1'b0);
    bus.i_Enable = 1'b1;
    tick();
    chk("t4_next_dv", bus.o_Tx_DV, 1'b1);
    chk("t4_next_byte", bus.o_Tx_Byte, 8'h22);
    chk("t4_count0", bus.o_Count, 4'd0);
    bus.i_Enable = 1'b0;
    tick();
    bus.i_Enable = 1'b1;
    tick();

`ifdef UART_TX_FEEDER_TIMEOUT_EN
    // Watchdog: transmitter never goes active
    bus.i_Wr_En   = 1'b1;
    bus.i_Wr_Byte = 8'h31;
    tick();
    bus.i_Wr_Byte = 8'h32;
    tick();
    bus.i_Wr_En = 1'b0;
    chk("t5_dv", bus.o_Tx_DV, 1'b1);
    chk("t5_byte", bus.o_Tx_Byte, 8'h31);
    repeat (15) tick();
    chk("t5_tmo_early", bus.o_Timeout, 1'b0);
    chk("t5_busy_wait", bus.o_Busy, 1'b1);
    tick();
    chk("t5_tmo", bus.o_Timeout, 1'b1);
    chk("t5_idle", bus.o_Busy, 1'b0);
    tick();
    chk("t5_tmo_pulse", bus.o_Timeout, 1'b0);
    chk("t5_next_dv", bus.o_Tx_DV, 1'b1);
    chk("t5_next_byte", bus.o_Tx_Byte, 8'h32);
    bus.i_Enable = 1'b0;
    tick();
    bus.i_Enable = 1'b1;
    tick();
`else
    chk("t5_tmo_tied", bus.o_Timeout, 1'b0);
`endif

    // Reset while a launch is in progress with three bytes queued
    bus.i_Enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.i_Wr_En   = 1'b1;
      bus.i_Wr_Byte = 8'(8'h41 + i);
      tick();
    end
    bus.i_Wr_En = 1'b0;
    chk("t6_count4", bus.o_Count, 4'd4);
    bus.i_Enable = 1'b1;
    tick();
    chk("t6_dv", bus.o_Tx_DV, 1'b1);
    chk("t6_count3", bus.o_Count, 4'd3);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_dv", bus.o_Tx_DV, 1'b0);
    chk("t6_rst_byte", bus.o_Tx_Byte, 8'h00);
    chk("t6_rst_count", bus.o_Count, 4'd0);
    chk("t6_rst_empty", bus.o_Empty, 1'b1);
    chk("t6_rst_busy", bus.o_Busy, 1'b0);
    dv_snap = dv_cnt;
    tick();
    tick();
    rst = 1'b0;
    repeat (8) tick();
    chk("t6_no_dv_after_rst", dv_cnt, dv_snap);
    chk("t6_busy_after_rst", bus.o_Busy, 1'b0);
    bus.i_Wr_En   = 1'b1;
    bus.i_Wr_Byte = 8'h55;
    tick();
    bus.i_Wr_En = 1'b0;
    tick();
    chk("t6_new_dv", bus.o_Tx_DV, 1'b1);
    chk("t6_new_byte", bus.o_Tx_Byte, 8'h55);

    chk("dv_while_busy", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
